load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencer between the execute stage and the byte-addressed `rw_memory` word port. It turns LDR/STR/LDRB/STRB/LDRH/STRH-style requests into aligned word accesses. Sub-word stores use read-modify-write, and loads are extracted, sign- or zero-extended, or rotated. It also range-checks every access and reports a fault without touching memory.

## Interface
Parameters:
- MEM_SIZE, 64000, memory size in bytes; must match the attached `rw_memory` SIZE.

Ports:
- mclk  in  1  clock; all state changes on the rising edge.
- nreset  in  1  reset, asynchronous and active-low.
- req_valid  in  1  a request is presented.
- req_ready  out  1  the unit accepts a request at this edge; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  size code: 00 byte, 01 halfword, 10 word, 11 reserved (faults).
- req_signed  in  1  sign-extend sub-word loads; ignored for stores and word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid.
- mem_enable  out  1  to memory `enable`.
- mem_write_enable  out  1  to memory `write_enable`.
- mem_address  out  32  to memory `address`; always word-aligned ({addr[31:2],2'b00}).
- mem_data_out  out  32  to memory `data_in`.
- mem_data_in  in  32  from memory `data_out`; valid the cycle after a read-enabled edge.

## Operation
- States: IDLE, RD, CAP, WR, RESP. A handshake is req_valid && req_ready at a rising edge. On acceptance the unit latches size, signed, write, addr and wdata.
- Fault check at acceptance. Any of the following goes straight to RESP with resp_fault=1 and no memory access:
  - size=11.
  - Halfword with addr[0]=1.
  - Aligned address > MEM_SIZE-4.
- Transitions from IDLE:
  - Word store: IDLE→WR→RESP.
  - Load: IDLE→RD→CAP→RESP.
  - Byte or halfword store: IDLE→RD→CAP→WR→RESP.
  - RESP→IDLE always.
- RD drives mem_enable=1, mem_write_enable=0 and the aligned address.
- CAP samples mem_data_in.
  - Load, byte: lane = addr[1:0], value = (word >> 8·lane)[7:0], extended per req_signed.
  - Load, halfword: lane = addr[1], value = 16 bits, extended per req_signed.
  - Load, word: rotate right by 8·addr[1:0]. This is ARM7 unaligned-load behaviour.
  - Store: the merge buffer is the read word with the addressed byte replaced by wdata[7:0], or the addressed halfword replaced by wdata[15:0].
- WR drives mem_enable=1, mem_write_enable=1, the aligned address, and data.
  - Data is the merge buffer for sub-word stores.
  - Data is wdata unrotated for word stores; addr[1:0] is ignored.
- RESP: resp_valid=1 for exactly one cycle. resp_rdata and resp_fault are registered and hold until the next RESP.
- When mem_enable=0, mem_write_enable, mem_address and mem_data_out are 0.

## Timing
- Latency from the acceptance edge to the cycle resp_valid is high:
  - Fault: 1 cycle.
  - Word store: 2 cycles.
  - Load: 3 cycles.
  - Sub-word store: 4 cycles.
- req_ready is 0 from acceptance through RESP. The next request can be accepted only at the edge ending the first IDLE cycle after RESP, so there is no back-to-back acceptance.
- Exactly one memory write per store and at most one read per request. No memory signal is asserted for faulted requests.
- Reset values (nreset low, asynchronous):
  - State is IDLE, so req_ready=1 is combinational.
  - resp_valid=0, resp_rdata=0, resp_fault=0.
  - mem_enable=0, mem_write_enable=0, mem_address=0, mem_data_out=0.
- Reset mid-operation aborts the request. If reset asserts before the edge that would end WR, no write is issued. No response is generated for the aborted request. Memory contents are not reset.
- req_* inputs are ignored outside IDLE; they need not be held after acceptance.

## Test plan
- Word store 0xDEADBEEF to 0x1000, then word load 0x1000 → resp_rdata=0xDEADBEEF, fault=0. resp_valid comes 2 cycles after acceptance for the store and 3 for the load.
- Byte store 0x1A5 to 0x1002 over 0xDEADBEEF → word reads 0xDEA5BEEF. Signed byte load 0x1002 → 0xFFFFFFA5; unsigned → 0x000000A5. Store latency is 4 cycles, with exactly one RD and one WR.
- Halfword store 0x8001 to 0x1002 → word 0x8001BEEF. Signed halfword load 0x1002 → 0xFFFF8001. Halfword load at 0x1001 → fault after 1 cycle, mem_enable never high, memory unchanged.
- Memory word at 0x2000 = 0x11223344: word load 0x2001 → 0x44112233; word load 0x2003 → 0x22334411.
- MEM_SIZE=64000: word load at 63996 succeeds. Word load at 63997 (aligned 63996) succeeds. Word store at 64000 → fault, no write. size=11 → fault.
- Assert nreset during CAP of a byte store to 0x1000 holding 0x01020304 → all outputs at reset values, no WR cycle, and a later load returns 0x01020304.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Request/response and memory word-port bundle of the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
  // execute-stage request / response
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  // rw_memory word port
  logic        mem_enable;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;

  // Environment side: issues requests and answers as the memory.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_data_in,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_enable, mem_write_enable, mem_address, mem_data_out
  );

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_data_in,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_enable, mem_write_enable, mem_address, mem_data_out
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Byte/halfword/word load-store sequencer onto a word-wide
//               memory port, with read-modify-write sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int MEM_SIZE = 64000
) (
  input  wire logic         mclk,
  input  wire logic         nreset,
  load_store_unit_if.slave  bus
);

  localparam logic [2:0]  S_IDLE = 3'd0;
  localparam logic [2:0]  S_RD   = 3'd1;
  localparam logic [2:0]  S_CAP  = 3'd2;
  localparam logic [2:0]  S_WR   = 3'd3;
  localparam logic [2:0]  S_RESP = 3'd4;

  localparam logic [1:0]  c_size_byte = 2'b00;
  localparam logic [1:0]  c_size_half = 2'b01;
  localparam logic [1:0]  c_size_word = 2'b10;
  localparam logic [1:0]  c_size_rsvd = 2'b11;

  localparam logic [31:0] c_last_word = 32'(MEM_SIZE - 4);

  logic [2:0]  r_state;
  logic [2:0]  w_next;

  logic        r_write;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_fault;

  logic        w_accept;
  logic        w_fault_req;
  logic [31:0] w_aligned;
  logic [5:0]  w_shamt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rot;
  logic [31:0] w_load_val;
  logic [31:0] w_merged;

  assign w_accept  = bus.req_valid && (r_state == S_IDLE);
  assign w_aligned = {r_addr[31:2], 2'b00};

  // Request faults are decided from the live request so no access ever starts.
  assign w_fault_req = (bus.req_size == c_size_rsvd)
                    || ((bus.req_size == c_size_half) && bus.req_addr[0])
                    || ({bus.req_addr[31:2], 2'b00} > c_last_word);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge mclk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fault_req) begin
            w_next = S_RESP;
          end else if (bus.req_write && (bus.req_size == c_size_word)) begin
            w_next = S_WR;
          end else begin
            w_next = S_RD;
          end
        end
      end
      S_RD:    w_next = S_CAP;
      S_CAP:   w_next = r_write ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.mem_enable       = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.mem_address      = 32'd0;
    bus.mem_data_out     = 32'd0;
    case (r_state)
      S_IDLE: bus.req_ready = 1'b1;
      S_RD: begin
        bus.mem_enable  = 1'b1;
        bus.mem_address = w_aligned;
      end
      S_WR: begin
        bus.mem_enable       = 1'b1;
        bus.mem_write_enable = 1'b1;
        bus.mem_address      = w_aligned;
        bus.mem_data_out     = (r_size == c_size_word) ? r_wdata : r_merge;
      end
      S_RESP: bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.resp_rdata = r_rdata;
  assign bus.resp_fault = r_fault;

  // ------------------------------------------------------- load extraction
  assign w_shamt = {1'b0, r_addr[1:0], 3'b000};
  assign w_byte  = bus.mem_data_in[{r_addr[1:0], 3'b000} +: 8];
  assign w_half  = r_addr[1] ? bus.mem_data_in[31:16] : bus.mem_data_in[15:0];
  // Unaligned word loads rotate the containing word (ARM7 behaviour).
  assign w_rot   = (bus.mem_data_in >> w_shamt)
                 | (bus.mem_data_in << (6'd32 - w_shamt));

  always_comb begin
    w_load_val = w_rot;
    case (r_size)
      c_size_byte: w_load_val = {{24{r_signed & w_byte[7]}}, w_byte};
      c_size_half: w_load_val = {{16{r_signed & w_half[15]}}, w_half};
      default:     w_load_val = w_rot;
    endcase
  end

  // ----------------------------------------------------- store merge buffer
  always_comb begin
    w_merged = bus.mem_data_in;
    case (r_size)
      c_size_byte: w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      c_size_half: w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default:     w_merged = bus.mem_data_in;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  // Response registers only change on the edge entering RESP, so they hold
  // their value until the next response.
  always_ff @(posedge mclk or negedge nreset) begin
    if (!nreset) begin
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_merge  <= 32'd0;
      r_rdata  <= 32'd0;
      r_fault  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= bus.req_write;
        r_signed <= bus.req_signed;
        r_size   <= bus.req_size;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        if (w_fault_req) begin
          r_rdata <= 32'd0;
          r_fault <= 1'b1;
        end
      end
      if (r_state == S_CAP) begin
        r_merge <= w_merged;
        if (!r_write) begin
          r_rdata <= w_load_val;
          r_fault <= 1'b0;
        end
      end
      if (r_state == S_WR) begin
        r_rdata <= 32'd0;
        r_fault <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               behavioural rw_memory word port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int c_mem_size  = 64000;
  localparam int c_mem_words = c_mem_size / 4;

  logic mclk;
  logic nreset;
  int   n_vec;
  int   n_miss;
  int   rd_cnt;
  int   wr_cnt;
  logic [31:0] last_wr_addr;
  logic [31:0] mem [0:c_mem_words-1];

  load_store_unit_if bus ();

  load_store_unit #(.MEM_SIZE(c_mem_size)) dut (
    .mclk   (mclk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // rw_memory model: read data valid the cycle after a read-enabled edge.
  always @(posedge mclk) begin
    if (bus.mem_enable) begin
      if (bus.mem_write_enable) begin
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= bus.mem_address;
        if (bus.mem_address[31:2] < c_mem_words)
          mem[bus.mem_address[31:2]] <= bus.mem_data_out;
      end else begin
        rd_cnt <= rd_cnt + 1;
        if (bus.mem_address[31:2] < c_mem_words)
          bus.mem_data_in <= mem[bus.mem_address[31:2]];
      end
    end
  end

  initial begin
    rd_cnt          = 0;
    wr_cnt          = 0;
    last_wr_addr    = 32'd0;
    bus.mem_data_in = 32'd0;
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic flt,
                        output int nrd, output int nwr, output logic busy_ready);
    int rd0, wr0;
    @(negedge mclk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge mclk);
    #1;
    // Scramble the request lines: they must be ignored once accepted.
    bus.req_valid  = 1'b0;
    bus.req_write  = ~w;
    bus.req_size   = 2'(~sz);
    bus.req_signed = ~sg;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat        = -1;
    busy_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge mclk);
      if (bus.req_ready) busy_ready = 1'b1;
      if (bus.resp_valid) begin
        lat = k;
        break;
      end
    end
    rd  = bus.resp_rdata;
    flt = bus.resp_fault;
    nrd = rd_cnt - rd0;
    nwr = wr_cnt - wr0;
  endtask

  int          lat, nrd, nwr;
  logic [31:0] rd;
  logic        flt, br;

  task automatic test_reset();
    nreset        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    n_vec++; if (bus.req_ready !== 1'b1) begin n_miss++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_miss++; $display("FAIL rst_resp_valid got %b want 0", bus.resp_valid); end
    n_vec++; if (bus.resp_rdata !== 32'd0 || bus.resp_fault !== 1'b0) begin n_miss++; $display("FAIL rst_resp got %h/%b want 0/0", bus.resp_rdata, bus.resp_fault); end
    n_vec++; if ({bus.mem_enable, bus.mem_write_enable, bus.mem_address, bus.mem_data_out} !== 66'd0) begin n_miss++; $display("FAIL rst_mem got en=%b we=%b a=%h d=%h want all 0", bus.mem_enable, bus.mem_write_enable, bus.mem_address, bus.mem_data_out); end
    nreset = 1'b1;
  endtask

  task automatic test_word();
    do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEADBEEF, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (lat !== 2) begin n_miss++; $display("FAIL wst_lat got %0d want 2", lat); end
    n_vec++; if (rd !== 32'd0 || flt !== 1'b0) begin n_miss++; $display("FAIL wst_resp got %h/%b want 0/0", rd, flt); end
    n_vec++; if (nrd !== 0 || nwr !== 1) begin n_miss++; $display("FAIL wst_access got rd=%0d wr=%0d want 0/1", nrd, nwr); end
    n_vec++; if (br !== 1'b0) begin n_miss++; $display("FAIL wst_busy_ready got %b want 0", br); end
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (lat !== 3) begin n_miss++; $display("FAIL wld_lat got %0d want 3", lat); end
    n_vec++; if (rd !== 32'hDEADBEEF || flt !== 1'b0) begin n_miss++; $display("FAIL wld_data got %h/%b want deadbeef/0", rd, flt); end
    n_vec++; if (nrd !== 1 || nwr !== 0) begin n_miss++; $display("FAIL wld_access got rd=%0d wr=%0d want 1/0", nrd, nwr); end
    @(negedge mclk);
    n_vec++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_miss++; $display("FAIL resp_pulse got valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready); end
    n_vec++; if (bus.resp_rdata !== 32'hDEADBEEF) begin n_miss++; $display("FAIL resp_hold got %h want deadbeef", bus.resp_rdata); end
  endtask

  task automatic test_byte();
    do_req(1'b1, 2'b00, 1'b0, 32'h1002, 32'h1A5, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (lat !== 4) begin n_miss++; $display("FAIL bst_lat got %0d want 4", lat); end
    n_vec++; if (nrd !== 1 || nwr !== 1) begin n_miss++; $display("FAIL bst_access got rd=%0d wr=%0d want 1/1", nrd, nwr); end
    n_vec++; if (last_wr_addr !== 32'h1000) begin n_miss++; $display("FAIL bst_addr got %h want 00001000", last_wr_addr); end
    n_vec++; if (br !== 1'b0) begin n_miss++; $display("FAIL bst_busy_ready got %b want 0", br); end
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'hDEA5BEEF) begin n_miss++; $display("FAIL bst_word got %h want dea5beef", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'h1002, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'hFFFFFFA5 || lat !== 3) begin n_miss++; $display("FAIL bld_signed got %h lat %0d want ffffffa5 lat 3", rd, lat); end
    do_req(1'b0, 2'b00, 1'b0, 32'h1002, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'h000000A5) begin n_miss++; $display("FAIL bld_unsigned got %h want 000000a5", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'h1001, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'hFFFFFFBE) begin n_miss++; $display("FAIL bld_lane1 got %h want ffffffbe", rd); end
  endtask

  task automatic test_half();
    do_req(1'b1, 2'b01, 1'b0, 32'h1002, 32'h8001, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (lat !== 4 || nwr !== 1 || nrd !== 1) begin n_miss++; $display("FAIL hst got lat=%0d rd=%0d wr=%0d want 4/1/1", lat, nrd, nwr); end
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'h8001BEEF) begin n_miss++; $display("FAIL hst_word got %h want 8001beef", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h1002, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'hFFFF8001) begin n_miss++; $display("FAIL hld_signed got %h want ffff8001", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h1000, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'hFFFFBEEF) begin n_miss++; $display("FAIL hld_low got %h want ffffbeef", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h1001, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (lat !== 1 || flt !== 1'b1 || rd !== 32'd0) begin n_miss++; $display("FAIL hld_misalign got lat=%0d f=%b d=%h want 1/1/0", lat, flt, rd); end
    n_vec++; if (nrd !== 0 || nwr !== 0) begin n_miss++; $display("FAIL hld_misalign_mem got rd=%0d wr=%0d want 0/0", nrd, nwr); end
    do_req(1'b1, 2'b01, 1'b0, 32'h1003, 32'h5555, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (flt !== 1'b1 || nwr !== 0) begin n_miss++; $display("FAIL hst_misalign got f=%b wr=%0d want 1/0", flt, nwr); end
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'h8001BEEF || flt !== 1'b0) begin n_miss++; $display("FAIL hst_unchanged got %h/%b want 8001beef/0", rd, flt); end
  endtask

  task automatic test_rotate();
    do_req(1'b1, 2'b10, 1'b0, 32'h2000, 32'h11223344, lat, rd, flt, nrd, nwr, br);
    do_req(1'b0, 2'b10, 1'b0, 32'h2001, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'h44112233) begin n_miss++; $display("FAIL rot1 got %h want 44112233", rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'h2003, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'h22334411) begin n_miss++; $display("FAIL rot3 got %h want 22334411", rd); end
    do_req(1'b1, 2'b10, 1'b0, 32'h2002, 32'hCAFEF00D, lat, rd, flt, nrd, nwr, br);
    do_req(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'hCAFEF00D) begin n_miss++; $display("FAIL wst_unaligned got %h want cafef00d", rd); end
  endtask

  task automatic test_bounds();
    do_req(1'b1, 2'b10, 1'b0, 32'd63996, 32'h11223344, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (flt !== 1'b0 || nwr !== 1) begin n_miss++; $display("FAIL top_store got f=%b wr=%0d want 0/1", flt, nwr); end
    do_req(1'b0, 2'b10, 1'b0, 32'd63996, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'h11223344 || flt !== 1'b0) begin n_miss++; $display("FAIL top_load got %h/%b want 11223344/0", rd, flt); end
    do_req(1'b0, 2'b10, 1'b0, 32'd63997, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'h44112233 || flt !== 1'b0) begin n_miss++; $display("FAIL top_load_unal got %h/%b want 44112233/0", rd, flt); end
    do_req(1'b1, 2'b10, 1'b0, 32'd64000, 32'h12345678, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (flt !== 1'b1 || lat !== 1 || nwr !== 0 || nrd !== 0) begin n_miss++; $display("FAIL oob_store got f=%b lat=%0d rd=%0d wr=%0d want 1/1/0/0", flt, lat, nrd, nwr); end
    do_req(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFC, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (flt !== 1'b1 || nrd !== 0) begin n_miss++; $display("FAIL oob_high got f=%b rd=%0d want 1/0", flt, nrd); end
    do_req(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (flt !== 1'b1 || lat !== 1 || rd !== 32'd0 || nrd !== 0) begin n_miss++; $display("FAIL size11 got f=%b lat=%0d d=%h rd=%0d want 1/1/0/0", flt, lat, rd, nrd); end
  endtask

  task automatic test_reset_abort();
    int wr0;
    do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'h01020304, lat, rd, flt, nrd, nwr, br);
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, rd, flt, nrd, nwr, br);
    @(negedge mclk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h1000;
    bus.req_wdata = 32'hFF;
    wr0 = wr_cnt;
    @(posedge mclk);
    #1 bus.req_valid = 1'b0;
    @(negedge mclk);          // RD
    @(negedge mclk);          // CAP
    nreset = 1'b0;
    #1;
    n_vec++; if (bus.resp_rdata !== 32'd0 || bus.resp_fault !== 1'b0 || bus.resp_valid !== 1'b0) begin n_miss++; $display("FAIL abort_resp got v=%b d=%h f=%b want 0/0/0", bus.resp_valid, bus.resp_rdata, bus.resp_fault); end
    n_vec++; if (bus.mem_enable !== 1'b0 || bus.mem_write_enable !== 1'b0 || bus.mem_address !== 32'd0 || bus.mem_data_out !== 32'd0 || bus.req_ready !== 1'b1) begin n_miss++; $display("FAIL abort_mem got en=%b we=%b a=%h d=%h rdy=%b want 0/0/0/0/1", bus.mem_enable, bus.mem_write_enable, bus.mem_address, bus.mem_data_out, bus.req_ready); end
    @(posedge mclk);
    @(negedge mclk);
    nreset = 1'b1;
    br = 1'b0;
    repeat (4) begin
      @(negedge mclk);
      if (bus.resp_valid) br = 1'b1;
    end
    n_vec++; if (br !== 1'b0 || wr_cnt !== wr0) begin n_miss++; $display("FAIL abort_quiet got resp=%b writes=%0d want 0/0", br, wr_cnt - wr0); end
    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, rd, flt, nrd, nwr, br);
    n_vec++; if (rd !== 32'h01020304) begin n_miss++; $display("FAIL abort_mem_kept got %h want 01020304", rd); end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_rotate();
    test_bounds();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
